// File: rtl/gray_scale_pipe.sv
// gray_scale_pipe: two-stage RGB->gray converter, luma weights chosen per pixel by mode_i; `GRAY_BINARIZE_EN adds a threshold output.
// Latency 2 cycles at full rate; holds up to 2 pixels under backpressure, in_ready_o drops only when both stages are full and stalled.
module gray_scale_pipe #(
  parameter int PIXEL_W  = 8,
  parameter int WEIGHT_W = 9
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [1:0]           mode_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [3*PIXEL_W-1:0] in_px_rgb_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
`ifdef GRAY_BINARIZE_EN
  input  logic [PIXEL_W-1:0]   threshold_i,
  input  logic                 binarize_i,
`endif
  output logic [PIXEL_W-1:0]   out_px_gray_o
);

  localparam int PROD_W = PIXEL_W + WEIGHT_W;
  localparam int SUM_W  = PROD_W + 2;

  localparam logic [1:0] MODE_BT601 = 2'd0;
  localparam logic [1:0] MODE_BT709 = 2'd1;
  localparam logic [1:0] MODE_AVG   = 2'd2;
  localparam logic [1:0] MODE_GREEN = 2'd3;

  typedef struct packed {
    logic [PROD_W-1:0]  prod_r;
    logic [PROD_W-1:0]  prod_g;
    logic [PROD_W-1:0]  prod_b;
    logic               bin;
    logic [PIXEL_W-1:0] thr;
  } s1_dat_t;

  logic [WEIGHT_W-1:0] w_r;
  logic [WEIGHT_W-1:0] w_g;
  logic [WEIGHT_W-1:0] w_b;
  logic [PIXEL_W-1:0]  px_r;
  logic [PIXEL_W-1:0]  px_g;
  logic [PIXEL_W-1:0]  px_b;

  s1_dat_t s1_nxt;
  s1_dat_t s1_dat;
  logic    s1_vld;
  logic    s2_vld;
  logic    s1_load;
  logic    s2_load;

  logic [SUM_W-1:0]   sum_rnd;
  logic [PIXEL_W-1:0] gray;
  logic [PIXEL_W-1:0] gray_out;
  logic               unused_sum_bits;

  // Each weight set sums to 256 (1.0 in Q1.8), so the rounded sum never overflows PIXEL_W.
  always_comb begin
    w_r = WEIGHT_W'(77);
    w_g = WEIGHT_W'(150);
    w_b = WEIGHT_W'(29);
    case (mode_i)
      MODE_BT709: begin
        w_r = WEIGHT_W'(54);
        w_g = WEIGHT_W'(183);
        w_b = WEIGHT_W'(19);
      end
      MODE_AVG: begin
        w_r = WEIGHT_W'(85);
        w_g = WEIGHT_W'(86);
        w_b = WEIGHT_W'(85);
      end
      MODE_GREEN: begin
        w_r = WEIGHT_W'(0);
        w_g = WEIGHT_W'(256);
        w_b = WEIGHT_W'(0);
      end
      MODE_BT601: begin
        w_r = WEIGHT_W'(77);
        w_g = WEIGHT_W'(150);
        w_b = WEIGHT_W'(29);
      end
      default: begin
        w_r = WEIGHT_W'(77);
        w_g = WEIGHT_W'(150);
        w_b = WEIGHT_W'(29);
      end
    endcase
  end

  assign px_r = in_px_rgb_i[3*PIXEL_W-1 -: PIXEL_W];
  assign px_g = in_px_rgb_i[2*PIXEL_W-1 -: PIXEL_W];
  assign px_b = in_px_rgb_i[PIXEL_W-1 -: PIXEL_W];

  assign s2_load    = !s2_vld || out_ready_i;
  assign s1_load    = !s1_vld || s2_load;
  assign in_ready_o = s1_load && !reset_i;

  always_comb begin
    s1_nxt.prod_r = PROD_W'(px_r) * PROD_W'(w_r);
    s1_nxt.prod_g = PROD_W'(px_g) * PROD_W'(w_g);
    s1_nxt.prod_b = PROD_W'(px_b) * PROD_W'(w_b);
`ifdef GRAY_BINARIZE_EN
    s1_nxt.bin    = binarize_i;
    s1_nxt.thr    = threshold_i;
`else
    s1_nxt.bin    = 1'b0;
    s1_nxt.thr    = '0;
`endif
  end

  assign sum_rnd = SUM_W'(s1_dat.prod_r) + SUM_W'(s1_dat.prod_g)
                 + SUM_W'(s1_dat.prod_b) + SUM_W'(128);
  assign gray    = sum_rnd[PIXEL_W+7:8];
  assign unused_sum_bits = ^{sum_rnd[SUM_W-1:PIXEL_W+8], sum_rnd[7:0]};

  always_comb begin
    gray_out = gray;
    if (s1_dat.bin) begin
      gray_out = (gray >= s1_dat.thr) ? {PIXEL_W{1'b1}} : {PIXEL_W{1'b0}};
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_vld        <= 1'b0;
      s2_vld        <= 1'b0;
      out_px_gray_o <= '0;
    end else begin
      if (s1_load) begin
        s1_vld <= in_valid_i;
      end
      if (s2_load) begin
        s2_vld <= s1_vld;
        if (s1_vld) begin
          out_px_gray_o <= gray_out;
        end
      end
    end
  end

  // Payload needs no reset: it is only observed behind its valid bit.
  always_ff @(posedge clk_i) begin
    if (s1_load && in_valid_i) begin
      s1_dat <= s1_nxt;
    end
  end

  assign out_valid_o = s2_vld;

endmodule
